// File: rtl/eth_sma_master.sv
// eth_sma_master: IEEE 802.3 clause-22 MDIO/MDC management master.
// Takes one read/write command at a time, divides clk down to MDC
// (CLK_DIV clk per bit, low half first), and serializes the frame onto a
// split tri-state MDIO pad. Read data is taken through a 2-flop synchronizer.
// Optional build macro ETH_SMA_PREAMBLE_SUPPRESS_EN adds cfg_pre_sup, which
// skips the preamble once at least one frame has completed since reset.
module eth_sma_master #(
  parameter int CLK_DIV      = 8,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
`ifdef ETH_SMA_PREAMBLE_SUPPRESS_EN
  input  logic        cfg_pre_sup,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_nack,
  output logic        busy,
  output logic        eth_mdc,
  input  logic        eth_mdio_i,
  output logic        eth_mdio_o,
  output logic        eth_mdio_oen
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [5:0]       PRE_LAST = 6'(PREAMBLE_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       bit_q, bit_d;
  logic             wr_q, wr_d;
  logic [4:0]       phy_q, phy_d;
  logic [4:0]       reg_q, reg_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      shift_q, shift_d;
  logic             ta_q, ta_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             nack_q, nack_d;
  logic             sync1_q, sync2_q;
  logic             bit_end;
  logic             pre_skip;

  // Last clk of a bit period: also the last clk of the MDC high phase.
  assign bit_end = (div_q == DIV_LAST);

`ifdef ETH_SMA_PREAMBLE_SUPPRESS_EN
  logic seen_q;

  // Remembers that a full frame has completed since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_q <= 1'b0;
    else        seen_q <= seen_q | (state_q == S_DONE);
  end

  assign pre_skip = cfg_pre_sup & seen_q;
`else
  assign pre_skip = 1'b0;
`endif

  // Control state: FSM, MDC divider and per-phase bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
    end
  end

  // Command fields, read shift register and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      phy_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      shift_q <= '0;
      ta_q    <= 1'b0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      phy_q   <= phy_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
      ta_q    <= ta_d;
      rdata_q <= rdata_d;
      nack_q  <= nack_d;
    end
  end

  // Two-flop synchronizer for the asynchronous MDIO pad input (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= eth_mdio_i;
      sync2_q <= sync1_q;
    end
  end

  // Next state: accept commands when idle/done, walk the frame phases.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    wr_d    = wr_q;
    phy_d   = phy_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    ta_d    = ta_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (cmd_valid) begin
          wr_d    = cmd_write;
          phy_d   = cmd_phy_addr;
          reg_d   = cmd_reg_addr;
          wdata_d = cmd_wdata;
          div_d   = '0;
          if (pre_skip) begin
            state_d = S_ST;
            bit_d   = 6'd1;
          end else begin
            state_d = S_PRE;
            bit_d   = PRE_LAST;
          end
        end
      end
      default: begin
        div_d = bit_end ? '0 : div_q + 1'b1;
        if (bit_end) begin
          // Sample the PHY on the last clk of the high phase.
          if (!wr_q && state_q == S_TA && bit_q == 6'd0) ta_d = sync2_q;
          if (!wr_q && state_q == S_DATA) shift_d = {shift_q[14:0], sync2_q};
          if (bit_q != 6'd0) begin
            bit_d = bit_q - 6'd1;
          end else begin
            case (state_q)
              S_PRE:  begin state_d = S_ST;   bit_d = 6'd1;  end
              S_ST:   begin state_d = S_OP;   bit_d = 6'd1;  end
              S_OP:   begin state_d = S_PHY;  bit_d = 6'd4;  end
              S_PHY:  begin state_d = S_REG;  bit_d = 6'd4;  end
              S_REG:  begin state_d = S_TA;   bit_d = 6'd1;  end
              S_TA:   begin state_d = S_DATA; bit_d = 6'd15; end
              S_DATA: begin
                state_d = S_DONE;
                bit_d   = 6'd0;
                if (!wr_q) begin
                  rdata_d = {shift_q[14:0], sync2_q};
                  nack_d  = ta_q;
                end else begin
                  nack_d  = 1'b0;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Pad drive: master bits change at the start of each bit period.
  always_comb begin
    eth_mdio_o   = 1'b1;
    eth_mdio_oen = 1'b1;
    case (state_q)
      S_PRE: eth_mdio_oen = 1'b0;
      S_ST: begin
        eth_mdio_oen = 1'b0;
        eth_mdio_o   = ~bit_q[0];
      end
      S_OP: begin
        eth_mdio_oen = 1'b0;
        eth_mdio_o   = wr_q ? ~bit_q[0] : bit_q[0];
      end
      S_PHY: begin
        eth_mdio_oen = 1'b0;
        eth_mdio_o   = phy_q[bit_q[2:0]];
      end
      S_REG: begin
        eth_mdio_oen = 1'b0;
        eth_mdio_o   = reg_q[bit_q[2:0]];
      end
      S_TA: begin
        if (wr_q) begin
          eth_mdio_oen = 1'b0;
          eth_mdio_o   = bit_q[0];
        end
      end
      S_DATA: begin
        if (wr_q) begin
          eth_mdio_oen = 1'b0;
          eth_mdio_o   = wdata_q[bit_q[3:0]];
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_nack  = nack_q;
  assign eth_mdc   = busy && (div_q >= DIV_HALF);

endmodule

// File: tb/tb_eth_sma_master.sv
// tb_eth_sma_master: random and directed transactions against a clause-22
// PHY slave model (address 1, regs initialised to their own index) on a
// pulled-up MDIO line. Expected responses and serial frames come from a
// register-array reference built from the frame format.
module tb_eth_sma_master;

  localparam int         CLK_DIV      = 8;
  localparam int         PREAMBLE_LEN = 32;
  localparam int         N_BITS       = PREAMBLE_LEN + 32;
  localparam int         LAT          = N_BITS * CLK_DIV + 1;
  localparam logic [4:0] PHY_ADDR     = 5'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phy_addr = '0;
  logic [4:0]  cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_nack, busy;
  logic [15:0] rsp_rdata;
  logic        eth_mdc, eth_mdio_i, eth_mdio_o, eth_mdio_oen;
`ifdef ETH_SMA_PREAMBLE_SUPPRESS_EN
  logic        cfg_pre_sup = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  eth_sma_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_LEN(PREAMBLE_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_phy_addr (cmd_phy_addr),
    .cmd_reg_addr (cmd_reg_addr),
    .cmd_wdata    (cmd_wdata),
`ifdef ETH_SMA_PREAMBLE_SUPPRESS_EN
    .cfg_pre_sup  (cfg_pre_sup),
`endif
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_nack     (rsp_nack),
    .busy         (busy),
    .eth_mdc      (eth_mdc),
    .eth_mdio_i   (eth_mdio_i),
    .eth_mdio_o   (eth_mdio_o),
    .eth_mdio_oen (eth_mdio_oen)
  );

  // ---------------- MDIO line and PHY slave model ----------------
  logic        ph_drive = 1'b0;
  logic        ph_out = 1'b1;
  assign eth_mdio_i = ph_drive ? ph_out : (eth_mdio_oen ? 1'b1 : eth_mdio_o);

  logic [15:0] phy_regs [32];
  bit          ph_init = 1'b0;
  bit          ph_active = 1'b0;
  bit          ph_rd = 1'b0;
  bit          ph_wr = 1'b0;
  bit          ph_match = 1'b0;
  int          ph_ones = 0;
  int          ph_idx = 0;
  logic [12:0] ph_hdr = '0;
  logic [15:0] ph_wsh = '0;
  logic [15:0] ph_rword = '0;
  logic [4:0]  ph_reg = '0;
  logic        mdc_prev = 1'b0;
  logic        cap_line [$];
  logic        cap_oen [$];

  // The slave hunts for >=32 ones then ST; it acks TA only for its own
  // address and drives the data phase with its register (0 if not addressed).
  always @(eth_mdc or rst_n) begin
    if (!ph_init) begin
      for (int i = 0; i < 32; i++) phy_regs[i] = 16'(i);
      ph_init = 1'b1;
    end
    if (!rst_n) begin
      ph_active = 1'b0; ph_ones = 0; ph_idx = 0;
      ph_drive = 1'b0;  ph_out = 1'b1;
    end else if (eth_mdc && !mdc_prev) begin
      cap_line.push_back(eth_mdio_i);
      cap_oen.push_back(eth_mdio_oen);
      if (!ph_active) begin
        if (eth_mdio_i) ph_ones++;
        else begin
          if (ph_ones >= 32) begin ph_active = 1'b1; ph_idx = 1; end
          ph_ones = 0;
        end
      end else begin
        if (ph_idx <= 13) ph_hdr = {ph_hdr[11:0], eth_mdio_i};
        else if (ph_idx >= 16) ph_wsh = {ph_wsh[14:0], eth_mdio_i};
        if (ph_idx == 13) begin
          ph_rd    = (ph_hdr[11:10] == 2'b10);
          ph_wr    = (ph_hdr[11:10] == 2'b01);
          ph_match = (ph_hdr[9:5] == PHY_ADDR);
          ph_reg   = ph_hdr[4:0];
          ph_rword = ph_match ? phy_regs[ph_reg] : 16'h0000;
        end
        if (ph_idx == 31) begin
          if (ph_wr && ph_match) phy_regs[ph_reg] = ph_wsh;
          ph_active = 1'b0;
          ph_ones = 0;
        end
        ph_idx++;
      end
    end else if (!eth_mdc && mdc_prev) begin
      ph_drive = 1'b0;
      ph_out = 1'b1;
      if (ph_active && ph_rd) begin
        if (ph_idx == 15 && ph_match) begin
          ph_drive = 1'b1; ph_out = 1'b0;
        end else if (ph_idx >= 16 && ph_idx <= 31) begin
          ph_drive = 1'b1; ph_out = ph_rword[31 - ph_idx];
        end
      end
    end
    mdc_prev = eth_mdc;
  end

  // ---------------- reference model and checking ----------------
  logic [15:0] ref_regs [32];
  logic [15:0] last_rdata = '0;
  logic        t_w;
  logic [4:0]  t_p, t_r;
  logic [15:0] t_d;
  int          t_start;
  int          t_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present a command and wait (bounded) for the handshake edge.
  task automatic issue(input logic w, input logic [4:0] p, input logic [4:0] r, input logic [15:0] d);
    int guard;
    guard = 0;
    cmd_write = w; cmd_phy_addr = p; cmd_reg_addr = r; cmd_wdata = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 2000) begin
      @(posedge clk); #1; guard++;
    end
    check("cmd_ready_before_hs", cmd_ready, 1);
    t_w = w; t_p = p; t_r = r; t_d = d;
    t_start = cap_line.size();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_phy_addr = 5'($urandom);
    cmd_reg_addr = 5'($urandom); cmd_wdata = 16'($urandom);
    t_cyc = 1;
    check("busy_after_hs", {cmd_ready, busy}, 2'b01);
  endtask

  // Wait for the response and compare it and the serial frame to the model.
  task automatic complete(input string name);
    logic [63:0] got_line, got_oen, el, eo;
    logic [15:0] er;
    logic        en;
    bit          match;
    int          n;
    got_line = '0; got_oen = '0;
    while (!rsp_valid && t_cyc < LAT + 100) begin
      @(posedge clk); #1; t_cyc++;
    end
    check({name, "/latency"}, t_cyc, LAT);
    n = cap_line.size() - t_start;
    check({name, "/mdc_rises"}, n, N_BITS);
    for (int k = 0; k < N_BITS && t_start + k < cap_line.size(); k++) begin
      got_line = {got_line[62:0], cap_line[t_start + k]};
      got_oen  = {got_oen[62:0], cap_oen[t_start + k]};
    end
    match = (t_p == PHY_ADDR);
    if (t_w) begin
      el = {32'hFFFF_FFFF, 2'b01, 2'b01, t_p, t_r, 2'b10, t_d};
      eo = 64'h0;
      en = 1'b0;
      er = last_rdata;
      if (match) ref_regs[t_r] = t_d;
    end else begin
      er = match ? ref_regs[t_r] : 16'h0000;
      en = !match;
      el = {32'hFFFF_FFFF, 2'b01, 2'b10, t_p, t_r, 1'b1, !match, er};
      eo = 64'h3_FFFF;
      last_rdata = er;
    end
    check({name, "/mdio_stream"}, got_line, el);
    check({name, "/mdio_oen"}, got_oen, eo);
    check({name, "/rsp_nack"}, rsp_nack, en);
    check({name, "/rsp_rdata"}, rsp_rdata, er);
    check({name, "/ready_in_done"}, cmd_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          mdc_hi, oen_lo, busy_hi;
    int          vld_cnt;
    logic        w;
    logic [4:0]  p, r;
    logic [15:0] d;

    for (int i = 0; i < 32; i++) ref_regs[i] = 16'(i);
    rst_n = 1'b0;
    mdc_hi = 0; oen_lo = 0; busy_hi = 0;

    // Reset and idle hold.
    repeat (10) begin
      @(posedge clk); #1;
      if (eth_mdc) mdc_hi = 1;
      if (!eth_mdio_oen) oen_lo = 1;
    end
    check("rst/cmd_ready", cmd_ready, 1);
    check("rst/busy", busy, 0);
    check("rst/rsp_valid", rsp_valid, 0);
    check("rst/rsp_rdata", rsp_rdata, 0);
    check("rst/rsp_nack", rsp_nack, 0);
    check("rst/eth_mdio_o", eth_mdio_o, 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (eth_mdc) mdc_hi = 1;
      if (!eth_mdio_oen) oen_lo = 1;
      if (busy) busy_hi = 1;
    end
    check("idle/mdc_ever_high", mdc_hi, 0);
    check("idle/oen_ever_low", oen_lo, 0);
    check("idle/busy_ever_high", busy_hi, 0);

    // Write phy 1 reg 2.
    issue(1'b1, 5'd1, 5'd2, 16'hA5C3);
    complete("wr_r2");
    check("phy_reg02", phy_regs[2], 16'hA5C3);

    // Reads: matching and non-matching PHY address.
    issue(1'b0, 5'd1, 5'd3, 16'h0);
    complete("rd_r3");
    issue(1'b0, 5'd5, 5'd0, 16'h0);
    complete("rd_phy5");

    // Command while busy is ignored; back-to-back accept in the rsp cycle.
    issue(1'b0, 5'd1, 5'd1, 16'h0);
    repeat (100) begin @(posedge clk); #1; t_cyc++; end
    cmd_write = 1'b1; cmd_phy_addr = 5'd1; cmd_reg_addr = 5'd7; cmd_wdata = 16'hDEAD;
    cmd_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; t_cyc++; end
    check("busy/cmd_ready_low", cmd_ready, 0);
    cmd_valid = 1'b0;
    complete("rd_r1_busy");
    issue(1'b0, 5'd1, 5'd4, 16'h0);
    repeat (3) begin @(posedge clk); #1; t_cyc++; end
    check("b2b/mdc_low_c4", eth_mdc, 0);
    @(posedge clk); #1; t_cyc++;
    check("b2b/mdc_high_c5", eth_mdc, 1);
    complete("rd_r4_b2b");
    check("phy_reg07_untouched", phy_regs[7], 16'h0007);

    // Asynchronous reset at bit 40 of a read.
    issue(1'b0, 5'd1, 5'd3, 16'h0);
    while (t_cyc < 1 + 40 * CLK_DIV + 5) begin @(posedge clk); #1; t_cyc++; end
    check("abort/mdc_before", eth_mdc, 1);
    check("abort/oen_before", eth_mdio_oen, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort/mdc", eth_mdc, 0);
    check("abort/oen", eth_mdio_oen, 1);
    check("abort/mdio_o", eth_mdio_o, 1);
    check("abort/ready", {cmd_ready, busy}, 2'b10);
    check("abort/rsp_valid", rsp_valid, 0);
    check("abort/rsp_rdata", rsp_rdata, 0);
    last_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vld_cnt = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (rsp_valid) vld_cnt++;
    end
    check("abort/no_rsp_valid", vld_cnt, 0);
    issue(1'b1, 5'd1, 5'd0, 16'h1234);
    complete("wr_r0_after_rst");
    issue(1'b0, 5'd1, 5'd0, 16'h0);
    complete("rd_r0_after_rst");

    // Randomized transactions.
    for (int k = 0; k < 12; k++) begin
      w = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 3) == 0) ? 5'($urandom) : PHY_ADDR;
      r = 5'($urandom_range(0, 7));
      d = 16'($urandom);
      issue(w, p, r, d);
      complete($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_sma_master.md
Name: eth_sma_master

Overview:
Synthesizable Ethernet MAC-side SMA (MDIO/MDC) management master, IEEE 802.3 clause 22.
Accepts one read or write command at a time on a valid/ready interface, generates MDC from the system clock, and serializes the frame onto a split tri-state MDIO.
Returns read data plus the PHY turnaround ack bit on a one-cycle response strobe.
Sits between the MAC register block (AHB side) and the board MDIO pad; bench counterpart is the PHY SMA slave model.

Parameters:
CLK_DIV, 8, clk cycles per MDC period; even, >= 4. First half MDC low, second half MDC high.
PREAMBLE_LEN, 32, preamble bits (all 1) before ST.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  master idle, can accept a command
cmd_write  input  1  1 = write (OP 01), 0 = read (OP 10)
cmd_phy_addr  input  5  PHYAD
cmd_reg_addr  input  5  REGAD
cmd_wdata  input  16  write data
rsp_valid  output  1  one-cycle pulse, transaction done
rsp_rdata  output  16  read data; held until next read completes
rsp_nack  output  1  read: second TA bit sampled as 1; write: always 0
busy  output  1  equals ~cmd_ready
eth_mdc  output  1  management clock
eth_mdio_i  input  1  MDIO pad input
eth_mdio_o  output  1  MDIO pad output value
eth_mdio_oen  output  1  output enable, active low (1 = released / hi-z)

Behaviour:
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_nack=0, eth_mdc=0, eth_mdio_o=1, eth_mdio_oen=1.
- Handshake: command captured in the cycle cmd_valid & cmd_ready. cmd_ready drops the next cycle. Command fields are registered; inputs are don't-care afterwards. cmd_valid while busy is ignored, with no queueing.
- FSM: IDLE -> PRE (PREAMBLE_LEN bits) -> ST (0,1) -> OP (2) -> PHYAD (5, MSB first) -> REGAD (5, MSB first) -> TA (2) -> DATA (16, MSB first) -> DONE -> IDLE.
- Bit period: CLK_DIV clk. eth_mdc is low for the first CLK_DIV/2 cycles and high for the rest. MDC is idle low and toggles only while busy.
- Master-driven bits change on the first clk of the bit period (MDC falling/low phase). PHY data is therefore stable at each rising edge.
- Write: all bits driven, with eth_mdio_oen=0 and TA = 1,0.
- Read: oen=0 through REGAD. oen=1 from the start of TA through the end of DATA.
- Read sampling: eth_mdio_i passes through a 2-flop synchronizer. It is sampled on the last clk of each high phase.
  - TA bit 2 is sampled into rsp_nack.
  - DATA bits are shifted into a 16-bit register.
- DONE, one clk:
  - eth_mdio_oen=1, eth_mdio_o=1.
  - rsp_valid=1; rsp_rdata is updated (read only); cmd_ready=1.
- Latency: handshake in cycle 0. Frame occupies cycles 1..N*CLK_DIV, where N = PREAMBLE_LEN+32. rsp_valid is in cycle N*CLK_DIV+1 (default 513). A new command is accepted in that same cycle.
- Bit counter: 6 bits, counts down per phase; the divider counter wraps at CLK_DIV-1.
- Read with nack=1: data is still shifted in and reported; no retry.
- Async reset mid-frame: immediately returns to reset values. MDIO is released, no rsp_valid is issued, and the partial read data is discarded.

Optional Feature:
Macro ETH_SMA_PREAMBLE_SUPPRESS_EN.
- Defined: adds input cfg_pre_sup (1 bit, sampled at handshake). When 1 and at least one frame has completed since reset, the PRE state is skipped. N then becomes 32 (rsp_valid at cycle 32*CLK_DIV+1). The first frame after reset always carries the full preamble.
- Undefined: port absent; every frame has PREAMBLE_LEN preamble bits.

Test Plan:
1. Reset, then hold -> all outputs at reset values, eth_mdc constant 0, eth_mdio_oen=1.
2. Write phy 1, reg 2, data 16'hA5C3 -> rsp_valid at cycle 513, rsp_nack=0. MDIO serial stream = 32 ones, 01 01 00001 00010 10 1010010111000011. PHY model reg02 = 16'hA5C3.
3. Read phy 1, reg 3 after model init -> rsp_rdata=16'h0003, rsp_nack=0. eth_mdio_oen=1 during TA and all 16 data bits.
4. Read phy 5, reg 0 (address mismatch) -> rsp_nack=1, rsp_rdata=16'h0000.
5. Issue a second cmd_valid while busy, then a back-to-back read accepted in the rsp_valid cycle -> first command ignored. Second frame's MDC starts in the next cycle and returns 16'h0004 for reg 4.
6. Assert rst_n low at bit 40 of a read -> eth_mdio_oen=1 and eth_mdc=0 asynchronously, no rsp_valid. A following write phy 1 reg 0 data 16'h1234 succeeds normally.
